// File: rtl/mem_line_ctrl_pkg.sv
// Shared definitions for the cache-line memory controller.
// Holds the FSM state encoding, the line data width, the line address width
// and the width of the per-access timeout counter.
package mem_if_pkg;

    localparam int LINE_W  = 128;   // one cache line
    localparam int LADDR_W = 28;    // line address, byte address bits [31:4]
    localparam int CNT_W   = 10;    // wide enough for TIMEOUT up to 1023

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WB   = 3'd1,
        ST_GAP  = 3'd2,
        ST_RD   = 3'd3,
        ST_WR   = 3'd4,
        ST_RESP = 3'd5
    } state_t;

endpackage

// File: rtl/mem_line_ctrl_if.sv
// Bus bundle between a cache and the line controller, plus the controller's
// slow-memory side.
//   req_*  / wb_*  : cache request (valid/ready handshake) and victim line
//   resp_*         : one-cycle completion pulse with error flag and fill data
//   mem_*          : slow-memory strobes, address, data and ready pulse
// Modports:
//   slave  : the controller
//   master : the environment (cache + slow memory)
interface mem_line_ctrl_if;
    import mem_if_pkg::*;

    logic               req_valid;
    logic               req_ready;
    logic               req_write;
    logic               req_wb;
    logic [LADDR_W-1:0] req_addr;
    logic [LINE_W-1:0]  req_wdata;
    logic [LADDR_W-1:0] wb_addr;
    logic [LINE_W-1:0]  wb_wdata;
    logic               resp_valid;
    logic               resp_err;
    logic [LINE_W-1:0]  resp_rdata;
    logic               mem_read;
    logic               mem_write;
    logic [LADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0]  mem_wdata;
    logic [LINE_W-1:0]  mem_rdata;
    logic               mem_ready;

    modport slave (
        input  req_valid, req_write, req_wb, req_addr, req_wdata,
               wb_addr, wb_wdata, mem_rdata, mem_ready,
        output req_ready, resp_valid, resp_err, resp_rdata,
               mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_wb, req_addr, req_wdata,
               wb_addr, wb_wdata, mem_rdata, mem_ready,
        input  req_ready, resp_valid, resp_err, resp_rdata,
               mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_line_ctrl_wdog.sv
// Per-access watchdog for the line controller.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clr_i      : restart the count at 0 (start of each memory access)
//   en_i       : count this cycle (a strobe is outstanding)
//   expired_o  : this is the TIMEOUT-th waiting cycle of the current access
module mem_wdog
    import mem_if_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    // The counter reads 0 in the first strobe cycle, so reaching TIMEOUT-1
    // means TIMEOUT strobe cycles have elapsed without mem_ready.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_line_ctrl.sv
// Cache-line controller: accepts one line request at a time from a cache and
// performs it against a slow memory, optionally writing back a victim line
// before the fill.
//
// state | meaning
// IDLE  | req_ready high, waiting for req_valid
// WB    | mem_write of victim line to wb_addr outstanding
// GAP   | one dead cycle between writeback and fill, both strobes low
// RD    | mem_read of req_addr outstanding
// WR    | mem_write of req_wdata to req_addr outstanding
// RESP  | resp_valid high for one cycle (resp_err set on timeout)
//
// Ports: clk, rst (asynchronous active-high), bus (mem_line_ctrl_if.slave).
module mem_line_ctrl
    import mem_if_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic           clk,
    input  logic           rst,
    mem_line_ctrl_if.slave bus
);

    state_t             state_q, state_d;
    logic               mem_read_q, mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic [LADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               resp_valid_q, resp_valid_d;
    logic               resp_err_q, resp_err_d;
    logic [LINE_W-1:0]  resp_rdata_q, resp_rdata_d;
    // Fill address, kept for the read that follows a writeback.  The other
    // accepted fields live directly in mem_addr_q / mem_wdata_q.
    logic [LADDR_W-1:0] fill_addr_q, fill_addr_d;

    logic wdog_clr, wdog_en, wdog_expired;

    mem_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (wdog_clr),
        .en_i      (wdog_en),
        .expired_o (wdog_expired)
    );

    always_comb begin
        state_d      = state_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;
        fill_addr_d  = fill_addr_q;
        wdog_clr     = 1'b0;
        wdog_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    fill_addr_d = bus.req_addr;
                    wdog_clr    = 1'b1;
                    if (bus.req_write) begin
                        state_d     = ST_WR;
                        mem_write_d = 1'b1;
                        mem_addr_d  = bus.req_addr;
                        mem_wdata_d = bus.req_wdata;
                    end else if (bus.req_wb) begin
                        state_d     = ST_WB;
                        mem_write_d = 1'b1;
                        mem_addr_d  = bus.wb_addr;
                        mem_wdata_d = bus.wb_wdata;
                    end else begin
                        state_d    = ST_RD;
                        mem_read_d = 1'b1;
                        mem_addr_d = bus.req_addr;
                    end
                end
            end

            ST_WB, ST_WR: begin
                wdog_en = 1'b1;
                // mem_ready is checked before expiry so a ready on the last
                // allowed cycle still counts as success.
                if (bus.mem_ready) begin
                    if (state_q == ST_WB) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                    end
                end else if (wdog_expired) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else begin
                    mem_write_d = 1'b1;
                end
            end

            ST_GAP: begin
                state_d    = ST_RD;
                mem_read_d = 1'b1;
                mem_addr_d = fill_addr_q;
                wdog_clr   = 1'b1;
            end

            ST_RD: begin
                wdog_en = 1'b1;
                if (bus.mem_ready) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = bus.mem_rdata;
                end else if (wdog_expired) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else begin
                    mem_read_d = 1'b1;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            fill_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            fill_addr_q  <= fill_addr_d;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;

endmodule
